uart_rx_cfg: RTL

//   Parametrised UART receiver; next generation of the fixed 8N1 receiver.

---
 rtl/uart_rx_cfg.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional odd/even parity, 1 or 2 stop bits,
// 3-sample majority vote per bit, false-start rejection, framing/parity/break reporting.
module uart_rx_cfg #(
   parameter int unsigned CLKS_PER_BIT = 5208,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                 sclk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] po_data,
   output logic                 po_flag,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 break_det,
   output logic                 busy
);

   localparam int unsigned CW  = $clog2(CLKS_PER_BIT);
   localparam int unsigned MID = CLKS_PER_BIT / 2;

   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] SMP_A    = CW'(MID - 1);
   localparam logic [CW-1:0] SMP_B    = CW'(MID);
   localparam logic [CW-1:0] SMP_C    = CW'(MID + 1);
   localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
   localparam logic          PAR_ODD   = (PARITY == 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_WAIT_HI
   } state_t;

   state_t               state;
   logic                 s1, s2, s3;
   logic [CW-1:0]        cnt;
   logic [3:0]           bit_cnt;
   logic                 smp_a, smp_b;
   logic                 bit_maj;
   logic [DATA_BITS-1:0] sr;
   logic                 par_acc;
   logic                 par_bad;
   logic                 stop_bad;
   logic                 all_zero;

   // Third vote is the live s2 value, so the decision lands on the cnt = MID+1 edge.
   always_comb begin
      bit_maj = (smp_a & smp_b) | (smp_a & s2) | (smp_b & s2);
   end

   always_ff @(posedge sclk) begin
      if (rst) begin
         state      <= ST_IDLE;
         s1         <= 1'b1;
         s2         <= 1'b1;
         s3         <= 1'b1;
         cnt        <= '0;
         bit_cnt    <= '0;
         smp_a      <= 1'b1;
         smp_b      <= 1'b1;
         sr         <= '0;
         par_acc    <= 1'b0;
         par_bad    <= 1'b0;
         stop_bad   <= 1'b0;
         all_zero   <= 1'b0;
         po_data    <= '0;
         po_flag    <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         break_det  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         s1 <= rx;
         s2 <= s1;
         s3 <= s2;

         po_flag    <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         break_det  <= 1'b0;

         if (state == ST_IDLE || state == ST_WAIT_HI || cnt == CNT_LAST) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end

         if (cnt == SMP_A) smp_a <= s2;
         if (cnt == SMP_B) smp_b <= s2;

         case (state)
            ST_IDLE: begin
               if (s3 && !s2) begin
                  state    <= ST_START;
                  busy     <= 1'b1;
                  bit_cnt  <= '0;
                  par_acc  <= 1'b0;
                  par_bad  <= 1'b0;
                  stop_bad <= 1'b0;
                  all_zero <= 1'b1;
               end
            end

            ST_START: begin
               if (cnt == SMP_C && bit_maj) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  state <= ST_DATA;
               end
            end

            ST_DATA: begin
               if (cnt == SMP_C) begin
                  sr      <= {bit_maj, sr[DATA_BITS-1:1]};
                  par_acc <= par_acc ^ bit_maj;
                  if (bit_maj) all_zero <= 1'b0;
               end
               if (cnt == CNT_LAST) begin
                  if (bit_cnt == DATA_LAST) begin
                     bit_cnt <= '0;
                     state   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end

            ST_PARITY: begin
               if (cnt == SMP_C) begin
                  par_bad <= ((par_acc ^ bit_maj) != PAR_ODD);
                  if (bit_maj) all_zero <= 1'b0;
               end
               if (cnt == CNT_LAST) state <= ST_STOP;
            end

            ST_STOP: begin
               if (cnt == SMP_C) begin
                  if (bit_cnt == STOP_LAST) begin
                     po_data    <= sr;
                     po_flag    <= 1'b1;
                     parity_err <= par_bad;
                     frame_err  <= stop_bad | ~bit_maj;
                     break_det  <= all_zero & ~bit_maj;
                     bit_cnt    <= '0;
                     // Leaving at mid-stop lets a following start bit be caught with no gap.
                     if (bit_maj) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                     end else begin
                        state <= ST_WAIT_HI;
                     end
                  end else begin
                     if (bit_maj) all_zero <= 1'b0;
                     else         stop_bad <= 1'b1;
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end

            ST_WAIT_HI: begin
               if (s2) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end

            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
